// File: rtl/demux_1to2_buf_pkg.sv
// rtl/demux_1to2_buf_pkg.sv - shared widths for the 1-to-2 buffered demux
package demux_1to2_buf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/demux_1to2_buf_fifo2.sv
// rtl/demux_1to2_buf_fifo2.sv - two-entry FIFO with 1-bit wrapping pointers
import demux_1to2_buf_pkg::*;

module fifo2 #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam logic [1:0] FULL_OCC = 2'(DEPTH);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (occ == FULL_OCC);
  assign empty_o = (occ == 2'd0);
  assign head_o  = mem[rd_ptr];

  // Guard here too so a caller mistake can never overrun or underrun the buffer.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only occupancy decides validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/demux_1to2_buf.sv
// rtl/demux_1to2_buf.sv - 1-to-2 demux with a 2-entry buffer and delivery counter per port
import demux_1to2_buf_pkg::*;

module demux_1to2_buf #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              select_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out0_valid_o,
  input  logic              out0_ready_i,
  output logic [DATA_W-1:0] out0_data_o,
  output logic              out1_valid_o,
  input  logic              out1_ready_i,
  output logic [DATA_W-1:0] out1_data_o,
  output logic [CNT_W-1:0]  cnt0_o,
  output logic [CNT_W-1:0]  cnt1_o
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;

  // Ready follows only the selected buffer, so a full port never stalls the other.
  assign in_ready_o = select_i ? !full1 : !full0;

  assign push0 = in_valid_i && in_ready_o && !select_i;
  assign push1 = in_valid_i && in_ready_o &&  select_i;

  assign out0_valid_o = !empty0;
  assign out1_valid_o = !empty1;
  assign pop0 = out0_valid_o && out0_ready_i;
  assign pop1 = out1_valid_o && out1_ready_i;

  fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push0),
    .pop_i   (pop0),
    .data_i  (data_i),
    .full_o  (full0),
    .empty_o (empty0),
    .head_o  (out0_data_o)
  );

  fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push1),
    .pop_i   (pop1),
    .data_i  (data_i),
    .full_o  (full1),
    .empty_o (empty1),
    .head_o  (out1_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt0_o <= '0;
      cnt1_o <= '0;
    end else begin
      if (pop0) cnt0_o <= cnt0_o + 1'b1;
      if (pop1) cnt1_o <= cnt1_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb/tb_demux_1to2_buf.sv - directed self-checking bench for demux_1to2_buf
module tb_demux_1to2_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        select_i;
  logic [31:0] data_i;
  logic        out0_valid_o, out1_valid_o;
  logic        out0_ready_i, out1_ready_i;
  logic [31:0] out0_data_o, out1_data_o;
  logic [15:0] cnt0_o, cnt1_o;

  int tests_run = 0;
  int tests_failed = 0;

  demux_1to2_buf dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .select_i     (select_i),
    .data_i       (data_i),
    .out0_valid_o (out0_valid_o),
    .out0_ready_i (out0_ready_i),
    .out0_data_o  (out0_data_o),
    .out1_valid_o (out1_valid_o),
    .out1_ready_i (out1_ready_i),
    .out1_data_o  (out1_data_o),
    .cnt0_o       (cnt0_o),
    .cnt1_o       (cnt1_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; select_i = 1'b0; data_i = '0;
    out0_ready_i = 1'b0; out1_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst_out0_valid", 32'(out0_valid_o), 32'd0);
    check("rst_out1_valid", 32'(out1_valid_o), 32'd0);
    check("rst_cnt0", 32'(cnt0_o), 32'd0);
    check("rst_cnt1", 32'(cnt1_o), 32'd0);
    check("rst_ready_sel0", 32'(in_ready_o), 32'd1);
    select_i = 1'b1; #1;
    check("rst_ready_sel1", 32'(in_ready_o), 32'd1);

    // single word to port 0 with consumer ready
    select_i = 1'b0; data_i = 32'h11; in_valid_i = 1'b1; out0_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0; #1;
    check("p0_valid_next", 32'(out0_valid_o), 32'd1);
    check("p0_data_next", out0_data_o, 32'h11);
    check("p1_idle", 32'(out1_valid_o), 32'd0);
    tick();
    check("p0_cnt_after", 32'(cnt0_o), 32'd1);
    check("p0_empty_after", 32'(out0_valid_o), 32'd0);
    check("p1_cnt_idle", 32'(cnt1_o), 32'd0);
    // ready with nothing valid: no action
    tick();
    check("p0_idle_ready_cnt", 32'(cnt0_o), 32'd1);
    out0_ready_i = 1'b0;

    // fill port 1, third offer stalls
    select_i = 1'b1; in_valid_i = 1'b1; data_i = 32'hA;
    tick();
    data_i = 32'hB;
    tick();
    data_i = 32'hC; #1;
    check("p1_full_ready", 32'(in_ready_o), 32'd0);
    check("p1_head_a", out1_data_o, 32'hA);
    out1_ready_i = 1'b1;
    tick();
    check("p1_head_b", out1_data_o, 32'hB);
    check("p1_ready_after_pop", 32'(in_ready_o), 32'd1);
    tick();
    check("p1_head_c", out1_data_o, 32'hC);
    check("p1_valid_c", 32'(out1_valid_o), 32'd1);
    in_valid_i = 1'b0;
    tick();
    check("p1_cnt3", 32'(cnt1_o), 32'd3);
    check("p1_drained", 32'(out1_valid_o), 32'd0);
    out1_ready_i = 1'b0;

    // port 0 full does not block port 1
    select_i = 1'b0; in_valid_i = 1'b1; data_i = 32'h1;
    tick();
    data_i = 32'h2;
    tick();
    #1;
    check("p0_full_ready", 32'(in_ready_o), 32'd0);
    select_i = 1'b1; data_i = 32'h55; #1;
    check("p1_ready_while_p0_full", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0; #1;
    check("p1_data_55", out1_data_o, 32'h55);
    check("p0_head_hold", out0_data_o, 32'h1);
    out1_ready_i = 1'b1;
    tick();
    out1_ready_i = 1'b0;
    check("p1_cnt4", 32'(cnt1_o), 32'd4);

    // drop port 0 to occupancy 1, then push and pop together
    out0_ready_i = 1'b1;
    tick();
    check("p0_head_2", out0_data_o, 32'h2);
    select_i = 1'b0; data_i = 32'h33; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("p0_pushpop_valid", 32'(out0_valid_o), 32'd1);
    check("p0_pushpop_head", out0_data_o, 32'h33);
    check("p0_pushpop_cnt", 32'(cnt0_o), 32'd3);
    check("p0_pushpop_ready", 32'(in_ready_o), 32'd1);
    tick();
    out0_ready_i = 1'b0;
    check("p0_cnt4", 32'(cnt0_o), 32'd4);
    check("p0_empty_final", 32'(out0_valid_o), 32'd0);

    // reset with both buffers full
    in_valid_i = 1'b1; select_i = 1'b0; data_i = 32'h61; tick();
    data_i = 32'h62; tick();
    select_i = 1'b1; data_i = 32'h71; tick();
    data_i = 32'h72; tick();
    in_valid_i = 1'b0;
    check("both_full_p0", 32'(out0_valid_o), 32'd1);
    check("both_full_ready1", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1; out0_ready_i = 1'b1; out1_ready_i = 1'b1;
    tick();
    rst_i = 1'b0; out0_ready_i = 1'b0; out1_ready_i = 1'b0; #1;
    check("mid_rst_v0", 32'(out0_valid_o), 32'd0);
    check("mid_rst_v1", 32'(out1_valid_o), 32'd0);
    check("mid_rst_cnt0", 32'(cnt0_o), 32'd0);
    check("mid_rst_cnt1", 32'(cnt1_o), 32'd0);
    check("mid_rst_ready1", 32'(in_ready_o), 32'd1);
    select_i = 1'b0; #1;
    check("mid_rst_ready0", 32'(in_ready_o), 32'd1);

    // stream port 1 until cnt1 reaches 0xFFFF, then one more delivery wraps
    select_i = 1'b1; in_valid_i = 1'b1; out1_ready_i = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      data_i = 32'(i);
      tick();
    end
    in_valid_i = 1'b0;
    check("wrap_pre_cnt", 32'(cnt1_o), 32'hFFFF);
    check("wrap_head", out1_data_o, 32'hFFFF);
    check("wrap_cnt0_quiet", 32'(cnt0_o), 32'd0);
    tick();
    check("wrap_cnt", 32'(cnt1_o), 32'h0);
    check("wrap_empty", 32'(out1_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
